// File: rtl/elev_pkg.sv
// Shared types and helpers for the elevator call scheduler.
// Holds the FSM encoding, default sizes and floor-sensor decoding.
package elev_pkg;

  localparam int N_FLOORS_D = 3;
  localparam int FW_D       = 2;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_DWELL    = 2'd2
  } state_t;

  function automatic logic [2:0] oh_to_idx(
    input logic [7:0] v
  );
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (v[i]) idx = 3'(i);
    return idx;
  endfunction

  function automatic logic is_onehot(
    input logic [7:0] v
  );
    return (v != '0) && ((v & (v - 8'd1)) == '0);
  endfunction

endpackage

// File: rtl/elev_scan_select.sv
// SCAN target selection: serve the current floor, else keep
// the current direction while calls remain ahead, else reverse.
module elev_scan_select
  import elev_pkg::*;
#(
  parameter int N_FLOORS = N_FLOORS_D,
  parameter int FW       = FW_D
) (
  input  logic [N_FLOORS-1:0] pending,
  input  logic [FW-1:0]       cur_floor,
  input  logic                dir_up,
  output logic                sel_valid,
  output logic [FW-1:0]       sel_floor,
  output logic                sel_dir_up
);

  logic          w_here;
  logic          w_up;
  logic          w_dn;
  logic [FW-1:0] w_above;
  logic [FW-1:0] w_below;

  // Descending scan leaves the nearest call above; ascending the nearest below.
  always_comb begin
    w_here  = 1'b0;
    w_up    = 1'b0;
    w_dn    = 1'b0;
    w_above = '0;
    w_below = '0;
    for (int f = N_FLOORS - 1; f >= 0; f--)
      if (pending[f] && FW'(f) > cur_floor) begin
        w_up    = 1'b1;
        w_above = FW'(f);
      end
    for (int f = 0; f < N_FLOORS; f++) begin
      if (pending[f] && FW'(f) < cur_floor) begin
        w_dn    = 1'b1;
        w_below = FW'(f);
      end
      if (pending[f] && FW'(f) == cur_floor)
        w_here = 1'b1;
    end
  end

  always_comb begin
    sel_valid  = 1'b1;
    sel_floor  = cur_floor;
    sel_dir_up = dir_up;
    if (w_here) begin
      sel_floor = cur_floor;
    end else if (dir_up && w_up) begin
      sel_floor = w_above;
    end else if (!dir_up && w_dn) begin
      sel_floor = w_below;
    end else if (w_up) begin
      sel_floor  = w_above;
      sel_dir_up = 1'b1;
    end else if (w_dn) begin
      sel_floor  = w_below;
      sel_dir_up = 1'b0;
    end else begin
      sel_valid = 1'b0;
    end
  end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Call latch, floor tracking and SCAN sequencer for the elevator core.
// One target at a time; served calls clear while the door dwells.
module elevator_call_scheduler
  import elev_pkg::*;
#(
  parameter int N_FLOORS     = N_FLOORS_D,
  parameter int FW           = FW_D,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [N_FLOORS-1:0] call_i,
  input  logic [N_FLOORS-1:0] call_e,
  input  logic [N_FLOORS-1:0] floor_sns,
  input  logic                door_open,
  output logic [FW-1:0]       target_floor,
  output logic                target_valid,
  output logic                dir_up,
  output logic [N_FLOORS-1:0] pending,
  output logic                busy,
  output logic                sns_err
);

  localparam int CW = $clog2(DWELL_CYCLES + 1);

  state_t              r_state;
  logic [N_FLOORS-1:0] r_pending;
  logic [FW-1:0]       r_cur;
  logic [FW-1:0]       r_tgt;
  logic                r_dir;
  logic                r_tv;
  logic                r_busy;
  logic                r_err;
  logic [CW-1:0]       r_cnt;

  logic [7:0]          w_sns8;
  logic                w_oh;
  logic [FW-1:0]       w_idx;
  logic                w_multi;
  logic                w_arrive;
  logic                w_between;
  logic                w_pend_at;
  logic                w_clr_en;
  logic [N_FLOORS-1:0] w_tgt_mask;
  logic [N_FLOORS-1:0] w_pend_nxt;
  logic                w_sel_valid;
  logic [FW-1:0]       w_sel_floor;
  logic                w_sel_dir;

  elev_scan_select #(
    .N_FLOORS (N_FLOORS),
    .FW       (FW)
  ) u_sel (
    .pending    (r_pending),
    .cur_floor  (r_cur),
    .dir_up     (r_dir),
    .sel_valid  (w_sel_valid),
    .sel_floor  (w_sel_floor),
    .sel_dir_up (w_sel_dir)
  );

  assign w_sns8    = 8'(floor_sns);
  assign w_oh      = is_onehot(w_sns8);
  assign w_idx     = FW'(oh_to_idx(w_sns8));
  assign w_multi   = (|floor_sns) & ~w_oh;
  assign w_arrive  = w_oh && (w_idx == r_tgt) && door_open;
  assign w_pend_at = w_oh && |(r_pending & floor_sns);
  assign w_between = r_dir ? (w_idx > r_cur && w_idx < r_tgt)
                           : (w_idx < r_cur && w_idx > r_tgt);

  // Served-floor clear; a press in the same cycle still survives.
  assign w_clr_en   = (r_state == S_DWELL) ||
                      (r_state == S_DISPATCH && w_arrive);
  assign w_tgt_mask = N_FLOORS'(1) << r_tgt;
  assign w_pend_nxt = (r_pending & ~(w_clr_en ? w_tgt_mask : '0))
                    | call_i | call_e;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_cur     <= '0;
      r_tgt     <= '0;
      r_dir     <= 1'b1;
      r_tv      <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_pending <= w_pend_nxt;
      if (w_oh)    r_cur <= w_idx;
      if (w_multi) r_err <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (w_sel_valid) begin
            r_state <= S_DISPATCH;
            r_tgt   <= w_sel_floor;
            r_dir   <= w_sel_dir;
            r_tv    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_DISPATCH: begin
          if (w_arrive) begin
            r_state <= S_DWELL;
            r_cnt   <= CW'(DWELL_CYCLES - 1);
          end else if (w_pend_at && w_between) begin
            r_tgt <= w_idx;
          end
        end
        S_DWELL: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (!door_open) begin
            if (w_sel_valid) begin
              r_state <= S_DISPATCH;
              r_tgt   <= w_sel_floor;
              r_dir   <= w_sel_dir;
            end else begin
              r_state <= S_IDLE;
              r_tv    <= 1'b0;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tv    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign target_floor = r_tgt;
  assign target_valid = r_tv;
  assign dir_up       = r_dir;
  assign pending      = r_pending;
  assign busy         = r_busy;
  assign sns_err      = r_err;

endmodule
